// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl
// Stream front end for aes_top. Collects command packets from a 32-bit
// AXI-Stream slave, assembles 128-bit blocks and 128/256-bit keys, fires a
// single en_key/en_cipher/en_decipher strobe, waits for the core's en_o, and
// returns each result block as four 32-bit words on an AXI-Stream master.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tlast  command/payload input stream
//   s_axis_tready              input word accepted when high
//   m_axis_tdata/tvalid/tlast  result output stream
//   m_axis_tready              downstream ready
//   en_key/en_cipher/en_decipher  one-cycle start strobes to the core
//   aes128_mode/aes256_mode    key-size levels, exactly one high
//   aes_key, aes_in_blk        key (MSB-aligned) and input block to the core
//   aes_out_blk, en_o          core result and its done pulse
//   busy                       high whenever the controller is not idle
//   err_cnt                    malformed packet count, saturates at 255
module aes_stream_ctrl #(
   parameter int DATA_W = 32,
   parameter int KEY_S  = 256,
   parameter int BLK_S  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic              en_cipher,
   output logic              en_decipher,
   output logic              en_key,
   output logic              aes128_mode,
   output logic              aes256_mode,
   output logic [KEY_S-1:0]  aes_key,
   output logic [BLK_S-1:0]  aes_in_blk,
   input  logic [BLK_S-1:0]  aes_out_blk,
   input  logic              en_o,
   output logic              busy,
   output logic [7:0]        err_cnt
);

   localparam int OUT_WORDS = BLK_S / DATA_W;

   typedef enum logic [2:0] {
      ST_IDLE, ST_RECV, ST_START, ST_WAIT, ST_SEND, ST_DRAIN
   } state_t;

   state_t             state_reg, state_next;
   logic               live_reg;      // holds tready low until the first clock after reset
   logic [3:0]         cmd_reg;
   logic [3:0]         cnt_reg;
   logic [KEY_S-1:0]   asm_reg;
   logic [KEY_S-1:0]   key_reg;
   logic [BLK_S-1:0]   blk_reg;
   logic [BLK_S-1:0]   out_reg;
   logic [1:0]         idx_reg;
   logic [7:0]         err_reg;
   logic               mode256_reg;

   logic               s_hs, m_hs;
   logic               cmd_hs, recv_hs, load_done, err_inc, capture;
   logic               cmd_valid;
   logic [3:0]         cnt_inc, exp_cnt;
   logic [KEY_S-1:0]   asm_shift;
   logic [DATA_W-1:0]  out_word [OUT_WORDS];

   // Result block split into stream words, word 0 taken from the MSBs.
   genvar gi;
   generate
      for (gi = 0; gi < OUT_WORDS; gi++) begin : g_out_word
         assign out_word[gi] = out_reg[BLK_S-1-DATA_W*gi -: DATA_W];
      end
   endgenerate

   assign s_axis_tready = live_reg &
                          ((state_reg == ST_IDLE) || (state_reg == ST_RECV) ||
                           (state_reg == ST_DRAIN));
   assign m_axis_tvalid = (state_reg == ST_SEND);
   assign m_axis_tlast  = (state_reg == ST_SEND) && (idx_reg == 2'd3);
   assign m_axis_tdata  = out_word[idx_reg];
   assign en_cipher     = (state_reg == ST_START) && cmd_reg[0];
   assign en_decipher   = (state_reg == ST_START) && cmd_reg[1];
   assign en_key        = (state_reg == ST_START) && cmd_reg[2];
   assign aes256_mode   = mode256_reg;
   assign aes128_mode   = ~mode256_reg;
   assign aes_key       = key_reg;
   assign aes_in_blk    = blk_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign err_cnt       = err_reg;

   assign s_hs      = s_axis_tvalid & s_axis_tready;
   assign m_hs      = m_axis_tvalid & m_axis_tready;
   assign cnt_inc   = cnt_reg + 4'd1;
   // Only a key command honours the size bit; blocks are always 4 words.
   assign exp_cnt   = (cmd_reg[2] & cmd_reg[3]) ? 4'd8 : 4'd4;
   // Words enter at the bottom, so the first word ends up at the top.
   assign asm_shift = {asm_reg[KEY_S-DATA_W-1:0], s_axis_tdata};

   always_comb begin
      case (s_axis_tdata[2:0])
         3'b001, 3'b010, 3'b100: cmd_valid = 1'b1;
         default:                cmd_valid = 1'b0;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      cmd_hs     = 1'b0;
      recv_hs    = 1'b0;
      load_done  = 1'b0;
      err_inc    = 1'b0;
      capture    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (s_hs) begin
               cmd_hs = 1'b1;
               if (cmd_valid) begin
                  state_next = ST_RECV;
               end else begin
                  err_inc    = 1'b1;
                  state_next = s_axis_tlast ? ST_IDLE : ST_DRAIN;
               end
            end
         end
         ST_RECV: begin
            if (s_hs) begin
               recv_hs = 1'b1;
               if (cnt_inc == exp_cnt) begin
                  if (s_axis_tlast) begin
                     load_done  = 1'b1;
                     state_next = ST_START;
                  end else begin
                     err_inc    = 1'b1;
                     state_next = ST_DRAIN;
                  end
               end else if (s_axis_tlast) begin
                  err_inc    = 1'b1;
                  state_next = ST_IDLE;
               end
            end
         end
         ST_START: state_next = ST_WAIT;
         ST_WAIT: begin
            if (en_o) begin
               if (cmd_reg[2]) begin
                  state_next = ST_IDLE;
               end else begin
                  capture    = 1'b1;
                  state_next = ST_SEND;
               end
            end
         end
         ST_SEND: begin
            if (m_hs && (idx_reg == 2'd3)) state_next = ST_IDLE;
         end
         ST_DRAIN: begin
            if (s_hs && s_axis_tlast) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         live_reg    <= 1'b0;
         cmd_reg     <= '0;
         cnt_reg     <= '0;
         asm_reg     <= '0;
         key_reg     <= '0;
         blk_reg     <= '0;
         out_reg     <= '0;
         idx_reg     <= '0;
         err_reg     <= '0;
         mode256_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         live_reg  <= 1'b1;
         if (cmd_hs) begin
            cmd_reg <= s_axis_tdata[3:0];
            cnt_reg <= '0;
         end
         if (recv_hs) begin
            asm_reg <= asm_shift;
            cnt_reg <= cnt_inc;
         end
         if (load_done) begin
            if (cmd_reg[2]) begin
               mode256_reg <= cmd_reg[3];
               key_reg     <= cmd_reg[3] ? asm_shift
                                         : {asm_shift[BLK_S-1:0], {(KEY_S-BLK_S){1'b0}}};
            end else begin
               blk_reg <= asm_shift[BLK_S-1:0];
            end
         end
         if (err_inc && (err_reg != 8'hFF)) err_reg <= err_reg + 8'd1;
         if (capture) begin
            out_reg <= aes_out_blk;
            idx_reg <= '0;
         end else if (m_hs) begin
            idx_reg <= idx_reg + 2'd1;
         end
      end
   end

endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Command/data front end for `aes_top`. It accepts a 32-bit AXI-Stream of command packets and assembles 128-bit blocks and 128/256-bit keys. It issues the one-cycle `en_key`/`en_cipher`/`en_decipher` strobes, waits for `en_o`, and serializes each result block onto a 32-bit AXI-Stream master. It sits directly upstream and downstream of `aes_top`, between the DMA/AXI fabric and the AES core.

## Interface
- `DATA_W`, 32: stream word width; only 32 is supported.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `s_axis_tdata` in 32: input word.
- `s_axis_tvalid` in 1: input word valid.
- `s_axis_tlast` in 1: last word of the packet.
- `s_axis_tready` out 1: controller accepts a word.
- `m_axis_tdata` out 32: result word.
- `m_axis_tvalid` out 1: result word valid.
- `m_axis_tlast` out 1: last word of the result block.
- `m_axis_tready` in 1: downstream accepts a word.
- `en_cipher`, `en_decipher`, `en_key` out 1: one-cycle start strobes to the core.
- `aes128_mode`, `aes256_mode` out 1: key-size levels; exactly one is high at any time.
- `aes_key` out `KEY_S` (256): key, MSB-aligned.
- `aes_in_blk` out `BLK_S` (128): input block.
- `aes_out_blk` in 128: core result, valid in the cycle `en_o` is high.
- `en_o` in 1: core done pulse.
- `busy` out 1: high in every state except IDLE.
- `err_cnt` out 8: count of malformed packets, saturating at 255.

## Operation
- The packet format is one command word, then payload words, with `tlast` on the final payload word. Words are packed MSB first: the first payload word lands in bits [top:top-31].
- Command word bits:
  - [0] encrypt.
  - [1] decrypt.
  - [2] key expand.
  - [3] key size: 1 = 256, 0 = 128. Honoured only on key commands.
  - [31:4] ignored.
- Payload length: 4 words for a block, 4 words for a 128-bit key, 8 words for a 256-bit key.
- A 128-bit key goes to `aes_key[255:128]`, and `aes_key[127:0]` is forced to 0.
- The key size is latched on each key command and persists. Block commands use the latched size.
- The state machine has six states:
  - IDLE: `tready`=1. On a command handshake, latch the command and clear the word counter.
    - Exactly one of bits [2:0] set → RECV.
    - Otherwise, with `tlast`=1 → IDLE and increment `err_cnt`.
    - Otherwise, with `tlast`=0 → DRAIN.
  - RECV: `tready`=1. Shift each word into a 256-bit assembly register and increment the counter.
    - `tlast` before the expected count → IDLE, increment `err_cnt`, no start.
    - Final expected word without `tlast` → DRAIN, increment `err_cnt`.
    - Final word with `tlast` → START.
  - START: `tready`=0. Assert exactly one `en_*` for one cycle; `aes_key`/`aes_in_blk` are already stable. → WAIT.
  - WAIT: `tready`=0. On `en_o`:
    - After a key command → IDLE, with no output.
    - After an encrypt or decrypt command → capture `aes_out_blk` into the output register → SEND.
  - SEND: present word 0 through word 3. Advance on `m_axis_tvalid & m_axis_tready`. Assert `m_axis_tlast` with word 3. After the word-3 handshake → IDLE.
  - DRAIN: `tready`=1. Discard words until a `tlast` handshake → IDLE.
- `aes_key` and `aes_in_blk` update only at RECV completion and stay stable until the next command completes.
- `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` hold steady while `tready` is low.
- The controller ignores an `en_o` seen outside WAIT.

## Timing
- Reset values:
  - State: IDLE.
  - Low: `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, all `en_*`, `busy`.
  - `m_axis_tdata`, `aes_key`, `aes_in_blk`, `err_cnt`: 0.
  - Mode: `aes128_mode`=1, `aes256_mode`=0.
  - `s_axis_tready` rises in the first cycle after reset deasserts.
- Sustained 1 word/cycle on input; no bubbles are inserted between command and payload.
- The `en_*` strobe fires in the cycle after the final payload handshake.
- `m_axis_tvalid` rises in the cycle after `en_o`. Output runs at 1 word/cycle when `m_axis_tready` is held high.
- One command is in flight at a time; no new input is accepted until the state returns to IDLE.
- Reset asserted mid-operation aborts immediately to reset values. Any partial packet is lost, and the core is reset by the same reset.

## Test plan
- AES-128 key expansion, then encryption:
  - Stimulus: cmd 0x4 with key 00010203_04050607_08090a0b_0c0d0e0f, then cmd 0x1 with block 00112233_44556677_8899aabb_ccddeeff.
  - Required: output words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with `tlast` on the 4th word.
- AES-256:
  - Stimulus: cmd 0xC with key 00010203…1c1d1e1f, then cmd 0x2 with block 8ea2b7ca_516745bf_eafc4990_4b496089.
  - Required: output 00112233_44556677_8899aabb_ccddeeff, and `aes256_mode`=1 throughout.
- Malformed packets:
  - Stimulus: cmd 0x3 with 4 words, then a block command with `tlast` on word 2, then a block command with `tlast` missing on word 4 followed by 2 extra words and then `tlast`.
  - Required: `err_cnt`=3, no `en_*` pulse, no output, and the controller accepts a valid encrypt afterwards.
- Output backpressure:
  - Stimulus: during SEND, toggle `m_axis_tready` 1,0,0,1,0,1,1.
  - Required: each word is held stable while stalled, exactly 4 handshakes occur, and `s_axis_tready`=0 until the last handshake completes.
- Asynchronous reset:
  - Stimulus: assert `reset` mid-WAIT and mid-SEND.
  - Required: outputs take their reset values in the same cycle, and a following full encrypt sequence gives the correct result.
- `err_cnt` saturation:
  - Stimulus: 300 malformed single-word packets.
  - Required: `err_cnt`=255.
